// File: rtl/bib_bellek_yanitlayici_pkg.sv
// Shared types and widths for the BIB memory responder.
package bib_bellek_yanitlayici_pkg;
  localparam int BIB_VERI_W  = 32;
  localparam int BIB_MASKE_W = 4;
  localparam int BIB_ADR_W   = 32;
  localparam int SAYAC_W     = 4;

  typedef enum logic [1:0] {
    BYY_BOSTA = 2'd0,
    BYY_BEKLE = 2'd1,
    BYY_TAMAM = 2'd2
  } durum_t;
endpackage

// File: rtl/bib_bellek_dizisi.sv
// Single-port word RAM built from four byte lanes: per-lane write enable,
// registered read with a clearable output register. Contents are never reset.
module bib_bellek_dizisi
  import bib_bellek_yanitlayici_pkg::*;
#(
  parameter int KELIME_SAYISI = 1024,
  parameter int AW            = $clog2(KELIME_SAYISI)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   oku_en,
  input  logic                   temizle,
  input  logic [BIB_MASKE_W-1:0] yaz_en,
  input  logic [AW-1:0]          adr,
  input  logic [BIB_VERI_W-1:0]  veri,
  output logic [BIB_VERI_W-1:0]  q
);
  for (genvar g = 0; g < BIB_MASKE_W; g++) begin : g_serit
    logic [7:0] mem [KELIME_SAYISI];
    logic [7:0] q_b;

    // byte-lane storage write
    always_ff @(posedge clk) begin
      if (yaz_en[g]) mem[adr] <= veri[8*g +: 8];
    end

    // read register: reset/clear to zero, otherwise holds until the next read
    always_ff @(posedge clk) begin
      if (rst)          q_b <= '0;
      else if (temizle) q_b <= '0;
      else if (oku_en)  q_b <= mem[adr];
    end

    assign q[8*g +: 8] = q_b;
  end
endmodule

// File: rtl/bib_bellek_yanitlayici.sv
// BIB data-memory responder: one request at a time, BEKLEME wait states, then a
// byte-masked write or a full-word read. Optional feature: BIB_YANIT_HATA_EN adds
// bib_hata_o and range checking (otherwise addresses wrap modulo KELIME_SAYISI).
module bib_bellek_yanitlayici
  import bib_bellek_yanitlayici_pkg::*;
#(
  parameter int          BEKLEME       = 2,
  parameter int          KELIME_SAYISI = 1024,
  parameter logic [31:0] ADR_TABAN     = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   bib_sec_i,
  input  logic                   bib_yaz_gecerli_i,
  input  logic [BIB_ADR_W-1:0]   bib_adr_i,
  input  logic [BIB_VERI_W-1:0]  bib_veri_i,
  input  logic [BIB_MASKE_W-1:0] bib_veri_maske_i,
  output logic [BIB_VERI_W-1:0]  bib_veri_o,
  output logic                   bib_durdur_o
`ifdef BIB_YANIT_HATA_EN
  , output logic                 bib_hata_o
`endif
);
  localparam int AW = $clog2(KELIME_SAYISI);
  localparam int YUKLE = (BEKLEME > 0) ? BEKLEME - 1 : 0;
  localparam logic [SAYAC_W-1:0] YUKLE_V = YUKLE[SAYAC_W-1:0];

  durum_t               durum, durum_d;
  logic [SAYAC_W-1:0]   sayac, sayac_d;
  logic [BIB_ADR_W-1:0] ofs;
  logic [AW-1:0]        idx;
  logic                 aralik;
  logic                 gir_tamam, oku_al, temizle;
  logic [BIB_MASKE_W-1:0] yaz_en;
  logic                 unused_bitler;

  // address decode: offset from base, word index wraps naturally via truncation
  assign ofs = bib_adr_i - ADR_TABAN;
  assign idx = ofs[AW+1:2];

`ifdef BIB_YANIT_HATA_EN
  logic hata_q;
  assign aralik = (bib_adr_i >= ADR_TABAN) &&
                  (64'(ofs) < 64'(KELIME_SAYISI) * 64'd4);
  assign bib_hata_o = hata_q;
  assign unused_bitler = ^ofs[1:0];
`else
  assign aralik = 1'b1;
  assign unused_bitler = ^{ofs[1:0], ofs[BIB_ADR_W-1:AW+2]};
`endif

  // next-state, wait counter and stall/write controls
  always_comb begin
    durum_d      = durum;
    sayac_d      = sayac;
    yaz_en       = '0;
    bib_durdur_o = bib_sec_i & (durum != BYY_TAMAM);
    case (durum)
      BYY_BOSTA: begin
        if (bib_sec_i) begin
          sayac_d = YUKLE_V;
          durum_d = (BEKLEME == 0) ? BYY_TAMAM : BYY_BEKLE;
        end
      end
      BYY_BEKLE: begin
        if (!bib_sec_i)       durum_d = BYY_BOSTA;
        else if (sayac == '0) durum_d = BYY_TAMAM;
        else                  sayac_d = sayac - 1'b1;
      end
      BYY_TAMAM: begin
        durum_d = BYY_BOSTA;
        // reset in the completion cycle still aborts the write
        if (bib_sec_i && bib_yaz_gecerli_i && aralik && !rst_i)
          yaz_en = bib_veri_maske_i;
      end
      default: durum_d = BYY_BOSTA;
    endcase
  end

  // read data is captured on the edge entering TAMAM; bad addresses clear it
  assign gir_tamam = (durum_d == BYY_TAMAM);
  assign oku_al    = gir_tamam & ~bib_yaz_gecerli_i & aralik;
  assign temizle   = gir_tamam & ~aralik;

  // state and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum <= BYY_BOSTA;
      sayac <= '0;
    end else begin
      durum <= durum_d;
      sayac <= sayac_d;
    end
  end

`ifdef BIB_YANIT_HATA_EN
  // error flag is high for the TAMAM cycle of an out-of-range access only
  always_ff @(posedge clk_i) begin
    if (rst_i) hata_q <= 1'b0;
    else       hata_q <= temizle;
  end
`endif

  bib_bellek_dizisi #(.KELIME_SAYISI(KELIME_SAYISI), .AW(AW)) u_dizi (
    .clk     (clk_i),
    .rst     (rst_i),
    .oku_en  (oku_al),
    .temizle (temizle),
    .yaz_en  (yaz_en),
    .adr     (idx),
    .veri    (bib_veri_i),
    .q       (bib_veri_o)
  );
endmodule

// File: tb/tb_bib_bellek_yanitlayici.sv
// Self-checking bench for bib_bellek_yanitlayici (BEKLEME=2, 1024 words, base 0).
module tb_bib_bellek_yanitlayici;
  logic        clk = 1'b0;
  logic        rst, sec, yaz;
  logic [31:0] adr, veri_i;
  logic [3:0]  maske;
  logic [31:0] veri_o;
  logic        durdur;
  logic        hata_sig;
  int          cyc = 0;
  int          n_karsi = 0;
  int          n_hata  = 0;
  logic [31:0] sb[$];
  logic [31:0] son_okuma;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bib_bellek_yanitlayici #(.BEKLEME(2), .KELIME_SAYISI(1024), .ADR_TABAN(32'h0)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .bib_sec_i         (sec),
    .bib_yaz_gecerli_i (yaz),
    .bib_adr_i         (adr),
    .bib_veri_i        (veri_i),
    .bib_veri_maske_i  (maske),
    .bib_veri_o        (veri_o),
    .bib_durdur_o      (durdur)
`ifdef BIB_YANIT_HATA_EN
    , .bib_hata_o      (hata_sig)
`endif
  );
`ifndef BIB_YANIT_HATA_EN
  assign hata_sig = 1'b0;
`endif

  // Drives one request from posedge+1 until completion; returns at posedge+1 with sec=0.
  task automatic bib_islem(input logic y, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m, output int lat, output logic [31:0] q,
                           output logic h, output int bitis);
    sec = 1'b1; yaz = y; adr = a; veri_i = d; maske = m;
    lat = -1; q = 'x; h = 1'bx; bitis = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!durdur) begin
        lat = i; q = veri_o; h = hata_sig; bitis = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    sec = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sec = 1'b1; yaz = 1'b0; adr = '0; veri_i = '0; maske = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_karsi++;
    if (durdur !== 1'b1) begin n_hata++; $display("FAIL reset_durdur_sec1 got %b want 1", durdur); end
    n_karsi++;
    if (veri_o !== 32'h0) begin n_hata++; $display("FAIL reset_veri got %h want 0", veri_o); end
    n_karsi++;
    if (hata_sig !== 1'b0) begin n_hata++; $display("FAIL reset_hata got %b want 0", hata_sig); end
    sec = 1'b0;
    #1;
    n_karsi++;
    if (durdur !== 1'b0) begin n_hata++; $display("FAIL reset_durdur_sec0 got %b want 0", durdur); end
    @(posedge clk); #1;
    rst = 1'b0;
    son_okuma = 32'h0;
  endtask

  task automatic test_yazma_okuma();
    int lat, b; logic [31:0] q; logic h;
    bib_islem(1'b1, 32'hF0, 32'h0000_0030, 4'hF, lat, q, h, b);
    n_karsi++;
    if (lat !== 3) begin n_hata++; $display("FAIL yazma_gecikme got %0d want 3", lat); end
    n_karsi++;
    if (q !== son_okuma) begin n_hata++; $display("FAIL yazma_veri_tut got %h want %h", q, son_okuma); end
    sb.push_back(32'h0000_0030);
    bib_islem(1'b0, 32'hF0, 32'h0, 4'hF, lat, q, h, b);
    n_karsi++;
    if (lat !== 3) begin n_hata++; $display("FAIL okuma_gecikme got %0d want 3", lat); end
    son_okuma = sb.pop_front();
    n_karsi++;
    if (q !== son_okuma) begin n_hata++; $display("FAIL okuma_F0 got %h want %h", q, son_okuma); end
  endtask

  task automatic test_maske();
    int lat, b; logic [31:0] q; logic h;
    logic [31:0] ops_d[4];
    logic [3:0]  ops_m[4];
    logic [31:0] bek[4];
    ops_d = '{32'h1122_3344, 32'h0000_00AB, 32'hCAFE_0000, 32'hFFFF_FFFF};
    ops_m = '{4'hF, 4'h1, 4'hC, 4'h0};
    bek   = '{32'h1122_3344, 32'h1122_33AB, 32'hCAFE_33AB, 32'hCAFE_33AB};
    for (int i = 0; i < 4; i++) begin
      bib_islem(1'b1, 32'h100, ops_d[i], ops_m[i], lat, q, h, b);
      n_karsi++;
      if (q !== son_okuma) begin n_hata++; $display("FAIL maske_yaz_veri_tut%0d got %h want %h", i, q, son_okuma); end
      sb.push_back(bek[i]);
      // the mask on a read must be ignored
      bib_islem(1'b0, 32'h100, 32'h0, 4'h0, lat, q, h, b);
      son_okuma = sb.pop_front();
      n_karsi++;
      if (q !== son_okuma) begin n_hata++; $display("FAIL maske_oku%0d got %h want %h", i, q, son_okuma); end
    end
  endtask

  task automatic test_abort();
    int lat, b; logic [31:0] q; logic h;
    bib_islem(1'b1, 32'h200, 32'h5555_AAAA, 4'hF, lat, q, h, b);
    sec = 1'b1; yaz = 1'b1; adr = 32'h200; veri_i = 32'hFFFF_FFFF; maske = 4'hF;
    @(negedge clk);
    n_karsi++;
    if (durdur !== 1'b1) begin n_hata++; $display("FAIL abort_durdur got %b want 1", durdur); end
    @(posedge clk); #1;
    sec = 1'b0;
    @(negedge clk);
    n_karsi++;
    if (durdur !== 1'b0) begin n_hata++; $display("FAIL abort_durdur_dus got %b want 0", durdur); end
    @(posedge clk); #1;
    sb.push_back(32'h5555_AAAA);
    bib_islem(1'b0, 32'h200, 32'h0, 4'hF, lat, q, h, b);
    n_karsi++;
    if (lat !== 3) begin n_hata++; $display("FAIL abort_sonra_gecikme got %0d want 3", lat); end
    son_okuma = sb.pop_front();
    n_karsi++;
    if (q !== son_okuma) begin n_hata++; $display("FAIL abort_bellek got %h want %h", q, son_okuma); end
  endtask

  task automatic test_back_to_back();
    int lat, b1, b2, bas; logic [31:0] q; logic h;
    bas = cyc;
    sb.push_back(32'h0000_0030);
    bib_islem(1'b0, 32'hF0, 32'h0, 4'hF, lat, q, h, b1);
    son_okuma = sb.pop_front();
    n_karsi++;
    if (q !== son_okuma) begin n_hata++; $display("FAIL b2b_veri1 got %h want %h", q, son_okuma); end
    sb.push_back(32'hCAFE_33AB);
    bib_islem(1'b0, 32'h100, 32'h0, 4'hF, lat, q, h, b2);
    son_okuma = sb.pop_front();
    n_karsi++;
    if (q !== son_okuma) begin n_hata++; $display("FAIL b2b_veri2 got %h want %h", q, son_okuma); end
    n_karsi++;
    if (b1 - bas !== 3) begin n_hata++; $display("FAIL b2b_bitis1 got %0d want 3", b1 - bas); end
    n_karsi++;
    if (b2 - bas !== 7) begin n_hata++; $display("FAIL b2b_bitis2 got %0d want 7", b2 - bas); end
  endtask

  task automatic test_reset_orta();
    int lat, b; logic [31:0] q; logic h;
    sec = 1'b1; yaz = 1'b1; adr = 32'hF0; veri_i = 32'hDEAD_BEEF; maske = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_karsi++;
    if (durdur !== 1'b1) begin n_hata++; $display("FAIL rst_orta_durdur got %b want 1", durdur); end
    @(posedge clk); #1;
    rst = 1'b0; sec = 1'b0;
    @(negedge clk);
    n_karsi++;
    if (veri_o !== 32'h0) begin n_hata++; $display("FAIL rst_orta_veri got %h want 0", veri_o); end
    son_okuma = 32'h0;
    @(posedge clk); #1;
    sb.push_back(32'h0000_0030);
    bib_islem(1'b0, 32'hF0, 32'h0, 4'hF, lat, q, h, b);
    n_karsi++;
    if (lat !== 3) begin n_hata++; $display("FAIL rst_orta_gecikme got %0d want 3", lat); end
    son_okuma = sb.pop_front();
    n_karsi++;
    if (q !== son_okuma) begin n_hata++; $display("FAIL rst_orta_bellek got %h want %h", q, son_okuma); end
  endtask

  task automatic test_aralik();
    int lat, b; logic [31:0] q; logic h;
    bib_islem(1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, lat, q, h, b);
`ifdef BIB_YANIT_HATA_EN
    sb.push_back(32'h0);
    bib_islem(1'b0, 32'h1000, 32'h0, 4'hF, lat, q, h, b);
    n_karsi++;
    if (lat !== 3) begin n_hata++; $display("FAIL aralik_gecikme got %0d want 3", lat); end
    n_karsi++;
    if (h !== 1'b1) begin n_hata++; $display("FAIL aralik_hata got %b want 1", h); end
    son_okuma = sb.pop_front();
    n_karsi++;
    if (q !== son_okuma) begin n_hata++; $display("FAIL aralik_veri got %h want %h", q, son_okuma); end
    @(negedge clk);
    n_karsi++;
    if (hata_sig !== 1'b0) begin n_hata++; $display("FAIL aralik_hata_tek got %b want 0", hata_sig); end
    @(posedge clk); #1;
    bib_islem(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, lat, q, h, b);
    n_karsi++;
    if (h !== 1'b1) begin n_hata++; $display("FAIL aralik_yaz_hata got %b want 1", h); end
`endif
    sb.push_back(32'h0BAD_F00D);
    bib_islem(1'b0, 32'h1000 - 32'h1000 * 32'(`ifdef BIB_YANIT_HATA_EN 1 `else 0 `endif), 32'h0, 4'hF, lat, q, h, b);
    son_okuma = sb.pop_front();
    n_karsi++;
    if (q !== son_okuma) begin n_hata++; $display("FAIL aralik_kelime0 got %h want %h", q, son_okuma); end
  endtask

  task automatic test_rastgele();
    int lat, b; logic [31:0] q; logic h;
    logic [31:0] model[8];
    logic [31:0] d, yeni;
    logic [3:0]  m;
    int          k;
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      bib_islem(1'b1, 32'h300 + 32'(i * 4), model[i], 4'hF, lat, q, h, b);
    end
    for (int n = 0; n < 16; n++) begin
      k = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom; m = 4'($urandom_range(0, 15));
        yeni = model[k];
        for (int l = 0; l < 4; l++) if (m[l]) yeni[8*l +: 8] = d[8*l +: 8];
        model[k] = yeni;
        bib_islem(1'b1, 32'h300 + 32'(k * 4) + 32'($urandom_range(0, 3)), d, m, lat, q, h, b);
      end else begin
        sb.push_back(model[k]);
        bib_islem(1'b0, 32'h300 + 32'(k * 4), 32'h0, 4'($urandom_range(0, 15)), lat, q, h, b);
        son_okuma = sb.pop_front();
        n_karsi++;
        if (q !== son_okuma) begin n_hata++; $display("FAIL rastgele_oku k=%0d got %h want %h", k, q, son_okuma); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_yazma_okuma();
    test_maske();
    test_abort();
    test_back_to_back();
    test_reset_orta();
    test_aralik();
    test_rastgele();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_karsi, n_hata);
    $finish;
  end
endmodule
